// File: rtl/led_blink_button_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
// The master modport is the Nios II data master side. The slave modport is the controller.
interface led_blink_button_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/led_blink_button_ctrl.sv
// Push-button controller on an Avalon-MM slave port.
// Each button pin is synchronised, debounced and edge detected.
// Detected edges are latched into a write-1-to-clear edgecapture register.
// The irq output is the OR of all captured edges whose irqmask bit is set.
//
// Optional feature: define BUTTON_DEBOUNCE_EN to build the per-bit debounce counters.
// Without that macro, the synchronised level is used directly as the stable level,
// and DEBOUNCE_CYCLES has no effect.
//
// Register map (word address):
//   0 data        RO, current stable button levels
//   1 reserved    reads 0
//   2 irqmask     RW
//   3 edgecapture sticky; writing 1 to a bit clears that bit
module led_blink_button_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESET_LEVEL     = 1,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       in_port,
  led_blink_button_ctrl_if.slave bus
);

  localparam logic             RST_BIT = (RESET_LEVEL != 0);
  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RST_BIT}};

  // A debounce window shorter than two cycles cannot be represented.
  // This elaboration-time hook marks that configuration as unsupported.
  if (DEBOUNCE_CYCLES < 2) begin : gDebounceTooShort
  end

  logic [WIDTH-1:0] syncMetaQ;
  logic [WIDTH-1:0] syncQ;
  logic [WIDTH-1:0] stableW;
  logic [WIDTH-1:0] stablePrevQ;
  logic [WIDTH-1:0] edgeW;
  logic [WIDTH-1:0] irqmaskQ;
  logic [WIDTH-1:0] irqmaskD;
  logic [WIDTH-1:0] edgecapQ;
  logic [WIDTH-1:0] edgecapD;
  logic [31:0]      readdataQ;
  logic [31:0]      readdataD;
  logic             wrEn;

  // Two-flop synchroniser. Both stages idle at the button rest level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncMetaQ <= RST_VEC;
      syncQ     <= RST_VEC;
    end else begin
      syncMetaQ <= in_port;
      syncQ     <= syncMetaQ;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] stableQ;
  logic [CNT_W-1:0] cntQ [WIDTH];

  // Per-bit debounce.
  // A new level is accepted only after it has differed from the stable level
  // for DEBOUNCE_CYCLES consecutive cycles.
  // Any return to the stable level restarts the count, so glitches are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stableQ <= RST_VEC;
      for (int i = 0; i < WIDTH; i++) begin
        cntQ[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (syncQ[i] == stableQ[i]) begin
          cntQ[i] <= '0;
        end else if (cntQ[i] == CNT_LAST) begin
          stableQ[i] <= syncQ[i];
          cntQ[i]    <= '0;
        end else begin
          cntQ[i] <= cntQ[i] + CNT_W'(1);
        end
      end
    end
  end

  assign stableW = stableQ;
`else
  // Without debouncing, the synchroniser output is taken as the stable level.
  assign stableW = syncQ;
`endif

  // Remember the previous stable level for edge detection.
  // This register resets to the rest level, so no edge is reported out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stablePrevQ <= RST_VEC;
    end else begin
      stablePrevQ <= stableW;
    end
  end

  // Select which transition counts as a button event.
  always_comb begin
    edgeW = '0;
    case (EDGE_TYPE)
      0:       edgeW = stablePrevQ & ~stableW;
      1:       edgeW = ~stablePrevQ & stableW;
      default: edgeW = stablePrevQ ^ stableW;
    endcase
  end

  assign wrEn = bus.chipselect & ~bus.write_n;

  // Next-state logic for the mask, the capture register and the read mux.
  // In edgecapture, the new edge is ORed in after the clear,
  // so a press that coincides with a clear is not lost.
  // Read data is taken from the register values before any same-cycle write.
  always_comb begin
    irqmaskD = irqmaskQ;
    if (wrEn && (bus.address == 2'd2)) begin
      irqmaskD = bus.writedata[WIDTH-1:0];
    end

    edgecapD = edgecapQ;
    if (wrEn && (bus.address == 2'd3)) begin
      edgecapD = edgecapQ & ~bus.writedata[WIDTH-1:0];
    end
    edgecapD = edgecapD | edgeW;

    readdataD = '0;
    case (bus.address)
      2'd0:    readdataD[WIDTH-1:0] = stableW;
      2'd2:    readdataD[WIDTH-1:0] = irqmaskQ;
      2'd3:    readdataD[WIDTH-1:0] = edgecapQ;
      default: readdataD = '0;
    endcase
  end

  // Register the mask, the captured edges and the read data.
  // Read data updates every clock, which gives a fixed read latency of one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmaskQ  <= '0;
      edgecapQ  <= '0;
      readdataQ <= '0;
    end else begin
      irqmaskQ  <= irqmaskD;
      edgecapQ  <= edgecapD;
      readdataQ <= readdataD;
    end
  end

  assign bus.readdata = readdataQ;
  assign bus.irq      = |(edgecapQ & irqmaskQ);

endmodule
